// File: rtl/alu_issue_ctrl_if.sv
// Handshake bundle for alu_issue_ctrl: decoded-instruction input channel and
// registered-result output channel.
interface alu_issue_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            ALUOp;
    logic [2:0]            Funct3;
    logic [6:0]            Funct7;
    logic [DATA_WIDTH-1:0] OpA;
    logic [DATA_WIDTH-1:0] OpB;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Result;
    logic                  BranchTaken;

    modport master (
        output in_valid, ALUOp, Funct3, Funct7, OpA, OpB, out_ready,
        input  in_ready, out_valid, Result, BranchTaken
    );

    modport slave (
        input  in_valid, ALUOp, Funct3, Funct7, OpA, OpB, out_ready,
        output in_ready, out_valid, Result, BranchTaken
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: decodes an instruction, drives the combinational ALU
// and registers its result. SLL is built from repeated self-ADDs.
module alu_issue_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_issue_ctrl_if.slave          bus,
    output logic [DATA_WIDTH-1:0]    alu_SrcA,
    output logic [DATA_WIDTH-1:0]    alu_SrcB,
    output logic [OPCODE_LENGTH-1:0] alu_Operation,
    input  logic [DATA_WIDTH-1:0]    alu_ALUResult
);
    localparam int unsigned ShW = $clog2(DATA_WIDTH);

    localparam logic [OPCODE_LENGTH-1:0] OpAnd     = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OpOr      = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OpAdd     = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OpXor     = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OpSub     = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OpEq      = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OpSlt     = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OpIllegal = OPCODE_LENGTH'(4'b1111);

    typedef enum logic [1:0] {StIdle, StExec, StShift, StDone} state_e;

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic                     branch_q, branch_d, inv_q, inv_d;
    logic [DATA_WIDTH-1:0]    acc_q, acc_d;
    logic [ShW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic                     taken_q, taken_d;

    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_branch, dec_inv, dec_sll;
    logic                     unused_funct7;

    assign unused_funct7 = ^{bus.Funct7[6], bus.Funct7[4:0]};

    // Illegal combinations keep the all-ones code so EXEC forces a zero result.
    always_comb begin
        dec_op     = OpIllegal;
        dec_branch = 1'b0;
        dec_inv    = 1'b0;
        dec_sll    = 1'b0;
        case (bus.ALUOp)
            2'b00: dec_op = OpAdd;
            2'b01: begin
                case (bus.Funct3)
                    3'b000: begin dec_op = OpEq;  dec_branch = 1'b1; end
                    3'b001: begin dec_op = OpEq;  dec_branch = 1'b1; dec_inv = 1'b1; end
                    3'b100: begin dec_op = OpSlt; dec_branch = 1'b1; end
                    3'b101: begin dec_op = OpSlt; dec_branch = 1'b1; dec_inv = 1'b1; end
                    default: ;
                endcase
            end
            2'b10: begin
                case (bus.Funct3)
                    3'b000:  dec_op = bus.Funct7[5] ? OpSub : OpAdd;
                    3'b111:  dec_op = OpAnd;
                    3'b110:  dec_op = OpOr;
                    3'b100:  dec_op = OpXor;
                    3'b010:  dec_op = OpSlt;
                    3'b001:  begin dec_op = OpAdd; dec_sll = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        branch_d      = branch_q;
        inv_d         = inv_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        result_d      = result_q;
        taken_d       = taken_q;
        alu_SrcA      = '0;
        alu_SrcB      = '0;
        alu_Operation = '0;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d      = bus.OpA;
                    b_d      = bus.OpB;
                    op_d     = dec_op;
                    branch_d = dec_branch;
                    inv_d    = dec_inv;
                    if (dec_sll) begin
                        acc_d   = bus.OpA;
                        cnt_d   = bus.OpB[ShW-1:0];
                        state_d = StShift;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                alu_SrcA      = a_q;
                alu_SrcB      = b_q;
                alu_Operation = op_q;
                result_d      = (op_q == OpIllegal) ? '0 : alu_ALUResult;
                taken_d       = branch_q & (alu_ALUResult[0] ^ inv_q);
                state_d       = StDone;
            end
            StShift: begin
                if (cnt_q == '0) begin
                    result_d = acc_q;
                    taken_d  = 1'b0;
                    state_d  = StDone;
                end else begin
                    // acc + acc doubles the accumulator: one left shift per cycle.
                    alu_SrcA      = acc_q;
                    alu_SrcB      = acc_q;
                    alu_Operation = OpAdd;
                    acc_d         = alu_ALUResult;
                    cnt_d         = cnt_q - ShW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OpAdd;
            branch_q <= 1'b0;
            inv_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            branch_q <= branch_d;
            inv_q    <= inv_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            taken_q  <= taken_d;
        end
    end

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.out_valid   = (state_q == StDone);
    assign bus.Result      = result_q;
    assign bus.BranchTaken = taken_q;
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage sequencer that drives the combinational ALU.
- Accepts a decoded instruction (ALUOp/Funct3/Funct7 plus operands) over a valid/ready handshake.
- Translates it into the ALU's 4-bit Operation code, drives SrcA/SrcB, and captures ALUResult into an output register with a valid/ready handshake.
- Builds ops the ALU lacks natively from ALU primitives: SLL as iterated ADD, and BNE/BGE as inverted EQ/SLT.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OPCODE_LENGTH, 4, width of ALU Operation code.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept.
- ALUOp  in  2  00 = load/store address, 01 = branch, 10 = R/I arithmetic, 11 = illegal.
- Funct3  in  3  RISC-V funct3.
- Funct7  in  7  RISC-V funct7; only bit 5 is used.
- OpA  in  DATA_WIDTH  first operand.
- OpB  in  DATA_WIDTH  second operand or immediate.
- alu_SrcA  out  DATA_WIDTH  to ALU SrcA.
- alu_SrcB  out  DATA_WIDTH  to ALU SrcB.
- alu_Operation  out  OPCODE_LENGTH  to ALU Operation.
- alu_ALUResult  in  DATA_WIDTH  from ALU, combinational.
- out_valid  out  1  Result valid.
- out_ready  in  1  consumer accepts.
- Result  out  DATA_WIDTH  registered result.
- BranchTaken  out  1  registered branch decision.

Behaviour:
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0101, SUB 0110, EQ 1000, SLT 1100. Any other code returns 0. SLT compares as the ALU defines; this block applies no signedness handling.
- Decode, latched at accept:
  - ALUOp 00: ADD.
  - ALUOp 01, Funct3 000 (BEQ): EQ.
  - ALUOp 01, Funct3 001 (BNE): EQ, inverted.
  - ALUOp 01, Funct3 100 (BLT): SLT.
  - ALUOp 01, Funct3 101 (BGE): SLT, inverted.
  - ALUOp 10, Funct3 000: ADD, or SUB if Funct7[5]=1.
  - ALUOp 10, Funct3 111: AND.
  - ALUOp 10, Funct3 110: OR.
  - ALUOp 10, Funct3 100: XOR.
  - ALUOp 10, Funct3 010: SLT.
  - ALUOp 10, Funct3 001: SLL.
  - All other combinations: ILLEGAL.
- States: IDLE, EXEC, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge E0: latch OpA, OpB and decoded op.
  - Next state is SHIFT if the op is SLL (acc<=OpA, cnt<=OpB[4:0]), otherwise EXEC.
  - in_ready=0 in every other state; in_valid is ignored there.
- EXEC (1 cycle):
  - Drive alu_SrcA/alu_SrcB from the latched operands and alu_Operation = decoded code.
  - At the edge: Result<=alu_ALUResult.
  - For branches: BranchTaken<=alu_ALUResult[0] XOR invert. For non-branches: BranchTaken<=0.
  - ILLEGAL: Operation driven as 1111, Result<=0, BranchTaken<=0.
  - Next state: DONE.
- SHIFT:
  - If cnt==0: Result<=acc, BranchTaken<=0, next state DONE.
  - Else: SrcA=SrcB=acc, Operation=ADD, acc<=alu_ALUResult (mod 2^DATA_WIDTH), cnt<=cnt-1.
  - Shift amount k occupies k+1 SHIFT cycles.
- DONE:
  - out_valid=1.
  - Result and BranchTaken are held stable while out_ready=0.
  - On out_ready=1: next state IDLE, out_valid drops at that edge.
- Outside EXEC/SHIFT: alu_SrcA=0, alu_SrcB=0, alu_Operation=0000.
- Latency from accept edge E0:
  - Non-SLL ops: out_valid high after E1.
  - SLL with amount k: out_valid high after E(k+1).
- Throughput: at most one op per 3 cycles. No overlap: the next accept happens only in IDLE.
- Reset, any state: next edge goes to IDLE and clears out_valid=0, Result=0, BranchTaken=0, acc=0, cnt=0, latched op = ADD. Any in-flight op is discarded, with no output. After reset: in_ready=1, ALU drive zeroed.
- Simultaneous in_valid with reset: reset wins, no accept.

Test Plan:
- ADD: ALUOp=10, F3=000, F7=0, A=5, B=7, out_ready=1 -> out_valid in the cycle after E1, Result=12, BranchTaken=0, then IDLE with in_ready=1.
- SUB/logic: F7=0100000, A=10, B=3 -> Result=7; F3=111, A=0xF0F0, B=0x0FF0 -> 0x00F0; ALUOp=11 -> Result=0.
- Branches, A=4, B=4:
  - BEQ -> BranchTaken=1.
  - BNE -> BranchTaken=0.
  - BGE with A=3, B=9 (SLT=1) -> BranchTaken=0.
  - BLT with A=3, B=9 -> BranchTaken=1, Result=1.
- SLL:
  - A=1, B=4 -> Result=0x10, out_valid after E5, alu_Operation=0010 during four SHIFT cycles.
  - B=0 -> Result=A after E1.
  - A=0x80000000, B=1 -> Result=0.
- Backpressure: out_ready=0 for 5 cycles after DONE while in_valid=1 with new operands -> Result/BranchTaken unchanged, in_ready=0, no accept. out_ready=1 -> IDLE; the new op is accepted the next cycle.
- Reset mid-SHIFT: A=1, B=20, assert reset during the 3rd SHIFT cycle -> out_valid=0, Result=0, in_ready=1 after that edge. A following ADD 2+2 -> Result=4.
